// File: rtl/aes_key_expand_rev_pkg.sv
// Shared AES constants for the reverse key-schedule walker: round count,
// rcon start/wrap values and the 128-bit key word-slicing layout.
package aes_key_expand_rev_pkg;

    // AES-128 round count; the walker supports only this value.
    localparam int unsigned NrAes128 = 10;

    // rcon used for the first backward step (round 10 -> 9).
    localparam logic [7:0] RconStart = 8'h36;

    // Inverse xtime of 8'h1b is 8'h80; every other value is a plain right shift.
    localparam logic [7:0] RconWrap     = 8'h1b;
    localparam logic [7:0] RconWrapNext = 8'h80;

    // Key layout: word 0 in the most significant 32 bits, word 3 in the least.
    localparam int unsigned KeyW   = 128;
    localparam int unsigned WordW  = 32;
    localparam int unsigned W0Lsb  = 96;
    localparam int unsigned W1Lsb  = 64;
    localparam int unsigned W2Lsb  = 32;
    localparam int unsigned W3Lsb  = 0;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] d_o
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // Inverse then affine transform.
    always_comb begin
        inv = gf_inv(a_i);
        d_o = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand_rev.sv
// Reverse AES-128 key schedule: loads the final round key and steps one
// round key backwards per accepted adv strobe, ending at the cipher key.
module aes_key_expand_rev
    import aes_key_expand_rev_pkg::*;
#(
    parameter int unsigned NR = NrAes128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kld,
    input  logic [KeyW-1:0] key_in,
    input  logic            adv,
    output logic [KeyW-1:0] key_out,
    output logic [3:0]      rnd,
    output logic [7:0]      rcon_out,
    output logic            kvld,
    output logic            done
);

    // Inverse xtime: walks the rcon sequence backwards (36,1b,80,40,...,01,00).
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return (x == RconWrap) ? RconWrapNext : {1'b0, x[7:1]};
    endfunction

    logic [KeyW-1:0] key_q, key_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            kvld_q, kvld_d;
    logic            done_q, done_d;

    logic [WordW-1:0] w0, w1, w2, w3;
    logic [WordW-1:0] p0, p1, p2, p3;
    logic [WordW-1:0] rot_p3, sub_p3;
    logic             step;

    assign w0 = key_q[W0Lsb +: WordW];
    assign w1 = key_q[W1Lsb +: WordW];
    assign w2 = key_q[W2Lsb +: WordW];
    assign w3 = key_q[W3Lsb +: WordW];

    // Previous round's words 1..3 fall out of adjacent XORs of the current ones.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // RotWord: left byte rotate of the recovered previous word 3.
    assign rot_p3 = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .a_i (rot_p3[8*g +: 8]),
            .d_o (sub_p3[8*g +: 8])
        );
    end

    assign p0 = w0 ^ sub_p3 ^ {rcon_q, 24'h0};

    // A step needs a valid key that is not already the cipher key.
    assign step = adv && kvld_q && (rnd_q != 4'd0);

    // Next-state: load beats step; otherwise everything holds.
    always_comb begin
        key_d  = key_q;
        rnd_d  = rnd_q;
        rcon_d = rcon_q;
        kvld_d = kvld_q;
        done_d = done_q;
        if (kld) begin
            key_d  = key_in;
            rnd_d  = 4'(NR);
            rcon_d = RconStart;
            kvld_d = 1'b1;
            done_d = 1'b0;
        end else if (step) begin
            key_d  = {p0, p1, p2, p3};
            rnd_d  = rnd_q - 4'd1;
            rcon_d = inv_xtime(rcon_q);
            done_d = (rnd_q == 4'd1);
        end
    end

    // State registers with synchronous reset taking priority over load/step.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '0;
            rnd_q  <= 4'h0;
            rcon_q <= 8'h00;
            kvld_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            key_q  <= key_d;
            rnd_q  <= rnd_d;
            rcon_q <= rcon_d;
            kvld_q <= kvld_d;
            done_q <= done_d;
        end
    end

    // rcon naturally reaches 8'h00 on the final step, so it drives rcon_out directly.
    assign key_out  = key_q;
    assign rnd      = rnd_q;
    assign rcon_out = rcon_q;
    assign kvld     = kvld_q;
    assign done     = done_q;

endmodule

// File: doc/aes_key_expand_rev.md
AES_KEY_EXPAND_REV -- requirements
Module: aes_key_expand_rev

Interface
REQ-001 SHALL have parameter NR, default 10, the number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port kld, input, 1, a load strobe that captures key_in as the final (round-NR) round key.
REQ-005 SHALL have port key_in, input, 128, the round-10 key; word 0 in [127:96], word 3 in [31:0].
REQ-006 SHALL have port adv, input, 1, a strobe that steps to the previous round key.
REQ-007 SHALL have port key_out, output, 128, the current round key, registered, with the same word order as key_in.
REQ-008 SHALL have port rnd, output, 4, the round index of key_out (10 down to 0).
REQ-009 SHALL have port rcon_out, output, 8, the rcon byte used for the step rnd to rnd-1; 8'h00 when rnd==0.
REQ-010 SHALL have port kvld, output, 1, asserted while key_out holds a valid loaded or derived key.
REQ-011 SHALL have port done, output, 1, asserted while rnd==0 and kvld==1 (key_out is the cipher key).

Function
REQ-012 On kld: key_out<=key_in, rnd<=10, rcon register<=8'h36, kvld<=1, done<=0; one-cycle latency.
REQ-013 On adv with kvld==1 and rnd!=0, key_out SHALL load the previous round key, computed from current words w0..w3:
  - p3=w3^w2
  - p2=w2^w1
  - p1=w1^w0
  - p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}
REQ-014 RotWord SHALL be a left byte rotate, {b1,b2,b3,b0}; SubWord SHALL apply the AES forward S-box bytewise.
REQ-015 On each accepted adv, rnd SHALL decrement by 1 and the rcon register SHALL step by inverse xtime:
  - 8'h1b -> 8'h80
  - otherwise right shift by 1
  - sequence: 36,1b,80,40,20,10,08,04,02,01
REQ-016 After the adv that takes rnd from 1 to 0: done<=1, rcon_out=8'h00, key_out=cipher key.
REQ-017 adv SHALL be ignored when rnd==0 or kvld==0; all outputs hold.
REQ-018 kld and adv in the same cycle: kld wins, and the step is not taken.
REQ-019 kld mid-walk SHALL restart from key_in at rnd=10 regardless of prior state.
REQ-020 With no kld or adv, all registers SHALL hold.
REQ-021 Each step SHALL be a single cycle (combinational derive plus register); no multicycle paths.

Reset
REQ-022 rst SHALL have priority over kld and adv.
REQ-023 Reset values: key_out=128'h0, rnd=4'h0, rcon register=8'h00, rcon_out=8'h00, kvld=0, done=0.
REQ-024 Asserting rst mid-walk SHALL abandon the walk; the next kld starts cleanly.

Structure
REQ-025 The shared AES package SHALL hold:
  - NR
  - the rcon start constant 8'h36
  - the 8'h1b wrap constant
  - the 128-bit word-slicing constants
REQ-026 SHALL instantiate the existing aes_sbox sub-module four times for SubWord; no local S-box table.
REQ-027 The inverse-xtime rcon step SHALL be a local function, not a lookup table.

Verification
REQ-028 Load the FIPS-197 A.1 round-10 key d014f9a8 c9ee2589 e13f0cc8 b6630ca6:
  - next cycle: key_out equals key_in, rnd=10, rcon_out=36, kvld=1, done=0.
REQ-029 From REQ-028, one adv -> key_out=ac7766f3 19fadc21 28d12941 575c006e, rnd=9, rcon_out=1b.
REQ-030 From REQ-028, ten advs (any spacing) -> key_out=2b7e1516 28aed2a6 abf71588 09cf4f3c, rnd=0, done=1, rcon_out=00.
  - an eleventh adv leaves all outputs unchanged.
REQ-031 kld and adv asserted together at rnd=5 -> rnd=10, key_out=key_in, no step.
REQ-032 rst pulsed at rnd=4 -> all outputs at reset values; adv without kld leaves them at reset values.
